// File: rtl/ex_stage.sv
// MIPS execute stage: operand select, ALU, branch target, EX/MEM registers.
// Define EX_MUL_EN to build the iterative shift-add multiplier and its stall handshake.
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_in,
    input  logic [2:0]  m_in,
    input  logic [3:0]  ex_in,
    input  logic [31:0] npc_in,
    input  logic [31:0] reg_rs_in,
    input  logic [31:0] reg_rt_in,
    input  logic [31:0] sign_ext_in,
    input  logic [4:0]  instr_20_16_in,
    input  logic [4:0]  instr_15_11_in,
    output logic        stall,
    output logic [1:0]  wb_out,
    output logic [2:0]  m_out,
    output logic [31:0] add_result,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2_out,
    output logic [4:0]  write_reg
);

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MULT = 6'h18;

    function automatic logic [31:0] alu_calc(input logic [1:0] op, input logic [5:0] fn,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            2'b00, 2'b11: r = 32'(a + b);
            2'b01:        r = 32'(a - b);
            default: begin
                case (fn)
                    FN_ADD:  r = 32'(a + b);
                    FN_SUB:  r = 32'(a - b);
                    FN_AND:  r = a & b;
                    FN_OR:   r = a | b;
                    FN_SLT:  r = {31'b0, (a < b)};
                    default: r = '0;
                endcase
            end
        endcase
        return r;
    endfunction

    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic [31:0] alu_val;
    logic [31:0] result_d;
    logic        bubble;
    logic        is_mul;

    assign alu_op  = ex_in[2:1];
    assign funct   = sign_ext_in[5:0];
    assign op_a    = reg_rs_in;
    assign op_b    = ex_in[0] ? sign_ext_in : reg_rt_in;
    assign alu_val = alu_calc(alu_op, funct, op_a, op_b);
    assign is_mul  = (alu_op == 2'b10) && (funct == FN_MULT);

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        mcand_q;
    logic [31:0]        mplier_q;
    logic [31:0]        prod_q;
    logic               hold;

    // Upstream is held from the entry cycle through the last iteration; DONE releases it.
    assign hold     = ((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY);
    assign stall    = !rst && hold;
    assign bubble   = hold;
    assign result_d = (state_q == S_DONE) ? prod_q : alu_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= reg_rs_in;
                        mplier_q <= op_b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (MUL_CYCLES == 0) & is_mul;
    assign stall      = 1'b0;
    assign bubble     = 1'b0;
    assign result_d   = alu_val;
`endif

    logic [1:0]  wb_q;
    logic [2:0]  m_q;
    logic [31:0] add_q;
    logic        zero_q;
    logic [31:0] alu_q;
    logic [31:0] rdata2_q;
    logic [4:0]  wreg_q;

    // EX/MEM boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q     <= '0;
            m_q      <= '0;
            add_q    <= '0;
            zero_q   <= 1'b0;
            alu_q    <= '0;
            rdata2_q <= '0;
            wreg_q   <= '0;
        end else begin
            wb_q     <= bubble ? 2'b00 : wb_in;
            m_q      <= bubble ? 3'b000 : m_in;
            add_q    <= npc_in + {sign_ext_in[29:0], 2'b00};
            zero_q   <= (result_d == 32'd0);
            alu_q    <= result_d;
            rdata2_q <= reg_rt_in;
            wreg_q   <= ex_in[3] ? instr_15_11_in : instr_20_16_in;
        end
    end

    assign wb_out     = wb_q;
    assign m_out      = m_q;
    assign add_result = add_q;
    assign zero       = zero_q;
    assign alu_result = alu_q;
    assign rdata2_out = rdata2_q;
    assign write_reg  = wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
// Follows EX_MUL_EN the same way the design does.
module tb_ex_stage;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  wb_in;
    logic [2:0]  m_in;
    logic [3:0]  ex_in;
    logic [31:0] npc_in;
    logic [31:0] reg_rs_in;
    logic [31:0] reg_rt_in;
    logic [31:0] sign_ext_in;
    logic [4:0]  instr_20_16_in;
    logic [4:0]  instr_15_11_in;
    logic        stall;
    logic [1:0]  wb_out;
    logic [2:0]  m_out;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2_out;
    logic [4:0]  write_reg;

    int n_tests = 0;
    int n_fail  = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
        .npc_in(npc_in), .reg_rs_in(reg_rs_in), .reg_rt_in(reg_rt_in),
        .sign_ext_in(sign_ext_in), .instr_20_16_in(instr_20_16_in),
        .instr_15_11_in(instr_15_11_in), .stall(stall), .wb_out(wb_out),
        .m_out(m_out), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rdata2_out(rdata2_out), .write_reg(write_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb"},    32'(wb_out), 32'd0);
        check({tag, "_m"},     32'(m_out), 32'd0);
        check({tag, "_add"},   add_result, 32'd0);
        check({tag, "_zero"},  32'(zero), 32'd0);
        check({tag, "_alu"},   alu_result, 32'd0);
        check({tag, "_rd2"},   rdata2_out, 32'd0);
        check({tag, "_wreg"},  32'(write_reg), 32'd0);
    endtask

    // Reference: what the instruction means, independent of how it is built.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [5:0] fn,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op != 2'b10) return (op == 2'b01) ? a - b : a + b;
        case (fn)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
            6'h18: return MUL_EN ? 32'((64'(a) * 64'(b)) & 64'hFFFF_FFFF) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Called just after a rising edge; applies one instruction, holds it while stalled.
    task automatic do_op(input string tag, input logic [3:0] ex, input logic [1:0] wb,
                         input logic [2:0] m, input logic [31:0] npc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm,
                         input logic [4:0] f_rt, input logic [4:0] f_rd);
        logic [31:0] b, exp_res;
        bit          mul;
        int          n;
        logic [4:0]  leak;
        ex_in = ex; wb_in = wb; m_in = m; npc_in = npc; reg_rs_in = rs; reg_rt_in = rt;
        sign_ext_in = imm; instr_20_16_in = f_rt; instr_15_11_in = f_rd;
        b       = ex[0] ? imm : rt;
        exp_res = ref_result(ex[2:1], imm[5:0], rs, b);
        mul     = MUL_EN && (ex[2:1] == 2'b10) && (imm[5:0] == 6'h18);
        #1;
        if (mul) begin
            n    = 0;
            leak = '0;
            while (stall && n < 100) begin
                @(posedge clk); #1;
                n++;
                leak |= {wb_out, m_out};
            end
            check({tag, "_stall_cycles"}, 32'(n), 32'd33);
            check({tag, "_bubbles"}, 32'(leak), 32'd0);
        end else begin
            check({tag, "_stall"}, 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "_wb"},   32'(wb_out), 32'(wb));
        check({tag, "_m"},    32'(m_out), 32'(m));
        check({tag, "_add"},  add_result, npc + (imm << 2));
        check({tag, "_alu"},  alu_result, exp_res);
        check({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
        check({tag, "_rd2"},  rdata2_out, rt);
        check({tag, "_wreg"}, 32'(write_reg), 32'(ex[3] ? f_rd : f_rt));
    endtask

    initial begin
        logic [5:0]  fn_tab [7];
        logic [31:0] imm;
        logic [3:0]  ex;
        logic [4:0]  leak;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h00};

        // Reset with random inputs, including a multiply to exercise forced-low stall.
        rst = 1'b1;
        wb_in = 2'($urandom); m_in = 3'($urandom); ex_in = 4'b0100;
        npc_in = $urandom; reg_rs_in = $urandom; reg_rt_in = $urandom;
        sign_ext_in = {$urandom_range(0, 1023), 6'h18} ; instr_20_16_in = 5'($urandom);
        instr_15_11_in = 5'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_stall", 32'(stall), 32'd0);
            check_reset_outputs("rst");
        end
        rst = 1'b0;

        do_op("radd",   4'b1100, 2'b11, 3'b000, 32'h0, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3);
        do_op("beq",    4'b0010, 2'b00, 3'b001, 32'h100, 32'h1234, 32'h1234, 32'd4, 5'd1, 5'd0);
        do_op("slt",    4'b1100, 2'b10, 3'b000, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd4, 5'd9);
        do_op("mul",    4'b1100, 2'b10, 3'b010, 32'h80, 32'd6, 32'hFFFF_FFFF, 32'h18, 5'd5, 5'd7);
        do_op("mul_b2b",4'b1100, 2'b01, 3'b100, 32'h84, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h18, 5'd6, 5'd8);
        do_op("mul0",   4'b0100, 2'b11, 3'b011, 32'h88, 32'd0, 32'h1234_5678, 32'h18, 5'd6, 5'd8);
        do_op("ifmt",   4'b0001, 2'b01, 3'b000, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFC, 5'd11, 5'd12);

        for (int i = 0; i < 40; i++) begin
            ex  = 4'($urandom);
            imm = $urandom;
            if (ex[2:1] == 2'b10) imm[5:0] = fn_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) imm = {{26{imm[5]}}, imm[5:0]};
            do_op("rnd", ex, 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, imm,
                  5'($urandom), 5'($urandom));
        end

        // Abort a multiply partway through the iterations.
        ex_in = 4'b1100; wb_in = 2'b11; m_in = 3'b111; npc_in = 32'h200;
        reg_rs_in = 32'd9; reg_rt_in = 32'd9; sign_ext_in = 32'h18;
        instr_20_16_in = 5'd1; instr_15_11_in = 5'd2;
        #1;
        check("abort_entry_stall", 32'(stall), 32'(MUL_EN));
        leak = '0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (MUL_EN) leak |= {wb_out, m_out};
        end
        check("abort_bubbles", 32'(leak), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst = 1'b0;
        do_op("post_add", 4'b1100, 2'b10, 3'b001, 32'h300, 32'd100, 32'd23, 32'h20, 5'd3, 5'd4);
        do_op("post_and", 4'b0100, 2'b01, 3'b010, 32'h304, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h24, 5'd5, 5'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
